// File: rtl/mlp_pkg.sv
// ---------------------------------------------------------------------------
// mlp_pkg
// Shared types and default constants for the MLP scoring path.
//   acc_state_t            : accuracy_counter run-control states
//   NUMBER_OF_LABELS       : number of legal classes (labels 0..N-1)
//   CLOG2_NUMBER_OF_LABELS : label width in bits
//   SAMPLE_COUNT           : samples per scoring run
//   ACC_CNT_W              : width of the accuracy counters
// ---------------------------------------------------------------------------
package mlp_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } acc_state_t;

  localparam int NUMBER_OF_LABELS       = 10;
  localparam int CLOG2_NUMBER_OF_LABELS = 4;
  localparam int SAMPLE_COUNT           = 750;
  localparam int ACC_CNT_W              = 16;

endpackage : mlp_pkg

// File: rtl/class_hit_bank.sv
// ---------------------------------------------------------------------------
// class_hit_bank
// Per-class correct-prediction counters for accuracy_counter. Only built
// when ACC_PER_CLASS_EN is defined; otherwise this file elaborates to
// nothing so that the default build carries no unused module.
//
// Ports
//   clk        in  : clock, rising edge
//   rst_n      in  : synchronous reset, active-low
//   clear      in  : zero every counter (start of a new run)
//   hit        in  : a correct, in-range prediction is being accepted
//   hit_label  in  : class of that prediction
//   class_hits out : counter k in bits [k*cnt_w +: cnt_w]
// ---------------------------------------------------------------------------
`ifdef ACC_PER_CLASS_EN
module class_hit_bank
  import mlp_pkg::*;
#(
  parameter int clog2_number_of_labels = CLOG2_NUMBER_OF_LABELS,
  parameter int number_of_labels       = NUMBER_OF_LABELS,
  parameter int cnt_w                  = ACC_CNT_W
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                clear,
  input  logic                                hit,
  input  logic [clog2_number_of_labels-1:0]   hit_label,
  output logic [number_of_labels*cnt_w-1:0]   class_hits
);

  for (genvar k = 0; k < number_of_labels; k++) begin : g_class
    localparam logic [clog2_number_of_labels-1:0] K_LABEL = clog2_number_of_labels'(k);

    logic [cnt_w-1:0] r_hits;

    // NOTE: these counters are architectural outputs with a defined reset
    // value, so each one is reset explicitly; a plain storage array with no
    // reset requirement would be left unreset.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        r_hits <= '0;
      end else if (clear) begin
        r_hits <= '0;
      end else if (hit && (hit_label == K_LABEL)) begin
        r_hits <= r_hits + 1'b1;
      end
    end

    assign class_hits[k*cnt_w +: cnt_w] = r_hits;
  end

endmodule : class_hit_bank
`endif

// File: rtl/accuracy_counter.sv
// ---------------------------------------------------------------------------
// accuracy_counter
// Scoring stage behind the label finder. Accepts one (predicted, true)
// label pair per cycle over a valid/ready handshake, counts correct and
// total predictions for a run of sample_count samples, then holds the final
// scores with done asserted until the next start.
//
// Optional feature macro: ACC_PER_CLASS_EN -- adds per-class hit counters
// (class_hit_bank) and the class_hits output port.
//
// Ports
//   clk           in  : clock, rising edge
//   rst_n         in  : synchronous reset, active-low
//   start         in  : begin a run (honoured in IDLE and DONE only)
//   pred_valid    in  : a label pair is presented
//   pred_ready    out : pair accepted this cycle if pred_valid (RUN only)
//   pred_label    in  : label from the label finder
//   true_label    in  : ground-truth label
//   busy          out : run in progress
//   done          out : run complete, scores final and held
//   correct_count out : correct predictions so far
//   total_count   out : samples accepted so far
//   bad_label     out : sticky, an out-of-range label was accepted
//   class_hits    out : per-class correct counts (ACC_PER_CLASS_EN only)
// ---------------------------------------------------------------------------
module accuracy_counter
  import mlp_pkg::*;
#(
  parameter int clog2_number_of_labels = CLOG2_NUMBER_OF_LABELS,
  parameter int number_of_labels       = NUMBER_OF_LABELS,
  parameter int sample_count           = SAMPLE_COUNT,
  parameter int cnt_w                  = ACC_CNT_W
) (
  input  logic                              clk,
  input  logic                              rst_n,
  input  logic                              start,
  input  logic                              pred_valid,
  output logic                              pred_ready,
  input  logic [clog2_number_of_labels-1:0] pred_label,
  input  logic [clog2_number_of_labels-1:0] true_label,
  output logic                              busy,
  output logic                              done,
  output logic [cnt_w-1:0]                  correct_count,
  output logic [cnt_w-1:0]                  total_count,
  output logic                              bad_label
`ifdef ACC_PER_CLASS_EN
  ,
  output logic [number_of_labels*cnt_w-1:0] class_hits
`endif
);

  // total_count value that the final handshake of a run sees before it
  // increments; matching it ends the run without a wider comparator.
  localparam logic [cnt_w-1:0] LAST_TOTAL = cnt_w'(sample_count - 1);

  acc_state_t       r_state;
  acc_state_t       w_state_next;
  logic [cnt_w-1:0] r_correct;
  logic [cnt_w-1:0] r_total;
  logic             r_bad;

  logic w_handshake;
  logic w_in_range;
  logic w_hit;
  logic w_clear;
  logic w_last;

  // Ready is decoded from state only, so the handshake never depends
  // combinationally on pred_valid reaching an output.
  assign w_handshake = pred_valid && (r_state == RUN);
  assign w_in_range  = (int'(pred_label) < number_of_labels) &&
                       (int'(true_label) < number_of_labels);
  assign w_hit       = w_handshake && w_in_range && (pred_label == true_label);
  assign w_clear     = start && (r_state != RUN);
  assign w_last      = w_handshake && (r_total == LAST_TOTAL);

  // NOTE: every variable assigned here gets a default first, so no path
  // through the case leaves it unassigned and no latch is inferred.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      IDLE:    if (start)  w_state_next = RUN;
      RUN:     if (w_last) w_state_next = DONE;
      DONE:    if (start)  w_state_next = RUN;
      default:             w_state_next = IDLE;
    endcase
  end

  // NOTE: reset is synchronous (sampled on the clock edge) and all state
  // uses non-blocking assignments so every flop updates from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_correct <= '0;
      r_total   <= '0;
      r_bad     <= 1'b0;
    end else if (w_clear) begin
      r_correct <= '0;
      r_total   <= '0;
      r_bad     <= 1'b0;
    end else if (w_handshake) begin
      r_total <= r_total + 1'b1;
      if (w_hit) begin
        r_correct <= r_correct + 1'b1;
      end
      if (!w_in_range) begin
        r_bad <= 1'b1;
      end
    end
  end

  assign pred_ready    = (r_state == RUN);
  assign busy          = (r_state == RUN);
  assign done          = (r_state == DONE);
  assign correct_count = r_correct;
  assign total_count   = r_total;
  assign bad_label     = r_bad;

`ifdef ACC_PER_CLASS_EN
  class_hit_bank #(
    .clog2_number_of_labels (clog2_number_of_labels),
    .number_of_labels       (number_of_labels),
    .cnt_w                  (cnt_w)
  ) u_class_hit_bank (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear      (w_clear),
    .hit        (w_hit),
    .hit_label  (pred_label),
    .class_hits (class_hits)
  );
`endif

endmodule : accuracy_counter

// File: tb/tb_accuracy_counter.sv
// ---------------------------------------------------------------------------
// tb_accuracy_counter
// Three accuracy_counter instances (sample_count 750, 4 and 2) on one clock
// and reset. Drivers issue label pairs; each accepted pair is recorded, and
// at the end of a run the expected scores are computed from that list and
// queued. A monitor pops the queue whenever an instance raises done, and on
// every cycle compares total_count with its own tally of handshakes and
// confirms that counts never move while the port is not ready.
// ---------------------------------------------------------------------------
module tb_accuracy_counter;

  localparam int NL  = 10;
  localparam int LW  = 4;
  localparam int CW  = 16;
  localparam int SC0 = 750;
  localparam int SC1 = 4;
  localparam int SC2 = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst_n;
  logic          start         [3];
  logic          pred_valid    [3];
  logic [LW-1:0] pred_label    [3];
  logic [LW-1:0] true_label    [3];
  logic          pred_ready    [3];
  logic          busy          [3];
  logic          done          [3];
  logic          bad_label     [3];
  logic [CW-1:0] correct_count [3];
  logic [CW-1:0] total_count   [3];
`ifdef ACC_PER_CLASS_EN
  logic [NL*CW-1:0] class_hits [3];
`endif

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int SC = (g == 0) ? SC0 : (g == 1) ? SC1 : SC2;
    accuracy_counter #(
      .clog2_number_of_labels (LW),
      .number_of_labels       (NL),
      .sample_count           (SC),
      .cnt_w                  (CW)
    ) u_dut (
      .clk           (clk),
      .rst_n         (rst_n),
      .start         (start[g]),
      .pred_valid    (pred_valid[g]),
      .pred_ready    (pred_ready[g]),
      .pred_label    (pred_label[g]),
      .true_label    (true_label[g]),
      .busy          (busy[g]),
      .done          (done[g]),
      .correct_count (correct_count[g]),
      .total_count   (total_count[g]),
      .bad_label     (bad_label[g])
`ifdef ACC_PER_CLASS_EN
      ,
      .class_hits    (class_hits[g])
`endif
    );
  end

  typedef struct packed {
    logic [CW-1:0]    correct;
    logic [CW-1:0]    total;
    logic             bad;
    logic [NL*CW-1:0] hits;
  } exp_t;

  exp_t       exp_q0[$];
  exp_t       exp_q1[$];
  exp_t       exp_q2[$];
  logic [7:0] pairs[$];   // accepted {pred, true} pairs of the current run
  int         checks = 0;
  int         errors = 0;
  bit         mon_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  // Reference scoring: plain counting over the list of accepted pairs.
  function automatic exp_t model();
    exp_t e;
    int   p;
    int   t;
    e       = '0;
    e.total = CW'(pairs.size());
    foreach (pairs[i]) begin
      p = int'(pairs[i][7:4]);
      t = int'(pairs[i][3:0]);
      if (p >= NL || t >= NL) begin
        e.bad = 1'b1;
      end else if (p == t) begin
        e.correct            = e.correct + 1'b1;
        e.hits[p*CW +: CW]   = e.hits[p*CW +: CW] + 1'b1;
      end
    end
    return e;
  endfunction

  task automatic push_exp(input int d, input exp_t e);
    case (d)
      0:       exp_q0.push_back(e);
      1:       exp_q1.push_back(e);
      default: exp_q2.push_back(e);
    endcase
  endtask

  task automatic do_start(input int d);
    pairs.delete();
    @(posedge clk); #1 start[d] = 1'b1;
    @(posedge clk); #1 start[d] = 1'b0;
    check($sformatf("dut%0d ready after start", d), 32'(pred_ready[d]), 1);
    check($sformatf("dut%0d total cleared", d), 32'(total_count[d]), 0);
    check($sformatf("dut%0d correct cleared", d), 32'(correct_count[d]), 0);
    check($sformatf("dut%0d bad cleared", d), 32'(bad_label[d]), 0);
  endtask

  // Present a pair, wait (bounded) for acceptance, then idle for gap cycles.
  task automatic send_pair(input int d, input int p, input int t, input int gap);
    int n;
    pred_label[d] = LW'(p);
    true_label[d] = LW'(t);
    pred_valid[d] = 1'b1;
    n = 0;
    while (!pred_ready[d] && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!pred_ready[d]) begin
      check($sformatf("dut%0d ready timeout", d), 0, 1);
      pred_valid[d] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    pairs.push_back({4'(p), 4'(t)});
    if (gap > 0) begin
      pred_valid[d] = 1'b0;
      repeat (gap) begin
        @(posedge clk); #1;
      end
    end
  endtask

  // Called one cycle after the final handshake of a run.
  task automatic finish_run(input int d, input int sc);
    exp_t e;
    e = model();
    push_exp(d, e);
    pred_valid[d] = 1'b0;
    check($sformatf("dut%0d done after last", d), 32'(done[d]), 1);
    check($sformatf("dut%0d ready low in done", d), 32'(pred_ready[d]), 0);
    check($sformatf("dut%0d busy low in done", d), 32'(busy[d]), 0);
    check($sformatf("dut%0d total final", d), 32'(total_count[d]), 32'(sc));
  endtask

  // Monitor / scoreboard.
  initial begin
    logic          p_ready [3] = '{1'b0, 1'b0, 1'b0};
    logic          p_start [3] = '{1'b0, 1'b0, 1'b0};
    logic          p_done  [3] = '{1'b0, 1'b0, 1'b0};
    logic [CW-1:0] p_total [3] = '{16'd0, 16'd0, 16'd0};
    logic [CW-1:0] p_corr  [3] = '{16'd0, 16'd0, 16'd0};
    logic          p_rst       = 1'b0;
    int            hs      [3] = '{0, 0, 0};
    exp_t          e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        for (int d = 0; d < 3; d++) begin
          check($sformatf("dut%0d handshake tally", d), 32'(total_count[d]), 32'(hs[d]));
          if (p_rst && !p_ready[d] && !p_start[d]) begin
            check($sformatf("dut%0d total held", d), 32'(total_count[d]), 32'(p_total[d]));
            check($sformatf("dut%0d correct held", d), 32'(correct_count[d]), 32'(p_corr[d]));
          end
          if (done[d] && !p_done[d]) begin
            if ((d == 0 && exp_q0.size() == 0) || (d == 1 && exp_q1.size() == 0) ||
                (d == 2 && exp_q2.size() == 0)) begin
              check($sformatf("dut%0d unexpected done", d), 1, 0);
            end else begin
              case (d)
                0:       e = exp_q0.pop_front();
                1:       e = exp_q1.pop_front();
                default: e = exp_q2.pop_front();
              endcase
              check($sformatf("dut%0d sb correct", d), 32'(correct_count[d]), 32'(e.correct));
              check($sformatf("dut%0d sb total", d), 32'(total_count[d]), 32'(e.total));
              check($sformatf("dut%0d sb bad", d), 32'(bad_label[d]), 32'(e.bad));
`ifdef ACC_PER_CLASS_EN
              for (int k = 0; k < NL; k++) begin
                check($sformatf("dut%0d sb hits[%0d]", d, k),
                      32'(class_hits[d][k*CW +: CW]), 32'(e.hits[k*CW +: CW]));
              end
`endif
            end
          end
          // Effect of the coming edge on the accepted-sample tally.
          if (!rst_n)                         hs[d] = 0;
          else if (start[d] && !busy[d])      hs[d] = 0;
          else if (pred_valid[d] && pred_ready[d]) hs[d]++;
          p_ready[d] = pred_ready[d];
          p_start[d] = start[d];
          p_done[d]  = done[d];
          p_total[d] = total_count[d];
          p_corr[d]  = correct_count[d];
        end
      end
      p_rst = rst_n;
    end
  end

  initial begin
    int p;
    int t;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) begin
      start[d]      = 1'b0;
      pred_valid[d] = 1'b0;
      pred_label[d] = '0;
      true_label[d] = '0;
    end
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("dut%0d reset ready", d), 32'(pred_ready[d]), 0);
      check($sformatf("dut%0d reset busy", d), 32'(busy[d]), 0);
      check($sformatf("dut%0d reset done", d), 32'(done[d]), 0);
      check($sformatf("dut%0d reset correct", d), 32'(correct_count[d]), 0);
      check($sformatf("dut%0d reset total", d), 32'(total_count[d]), 0);
      check($sformatf("dut%0d reset bad", d), 32'(bad_label[d]), 0);
`ifdef ACC_PER_CLASS_EN
      check($sformatf("dut%0d reset hits", d), 32'(class_hits[d] != '0), 0);
`endif
    end
    mon_en = 1'b1;
    @(posedge clk); #1 rst_n = 1'b1;

    // Full run, every prediction correct, back-to-back.
    do_start(0);
    for (int i = 0; i < SC0; i++) send_pair(0, i % 10, i % 10, 0);
    finish_run(0, SC0);
    check("dut0 all-correct count", 32'(correct_count[0]), 750);
    check("dut0 all-correct bad", 32'(bad_label[0]), 0);

    // Mixed hits and misses, then DONE hold and restart with valid high.
    do_start(1);
    send_pair(1, 3, 3, 0);
    send_pair(1, 1, 2, 1);
    send_pair(1, 7, 7, 0);
    send_pair(1, 0, 9, 0);
    finish_run(1, SC1);
    check("dut1 mixed correct", 32'(correct_count[1]), 2);
    pred_label[1] = 4'd2;
    true_label[1] = 4'd2;
    pred_valid[1] = 1'b1;
    repeat (5) begin
      @(posedge clk); #1;
    end
    check("dut1 done-hold total", 32'(total_count[1]), 4);
    check("dut1 done-hold correct", 32'(correct_count[1]), 2);
    do_start(1);
    send_pair(1, 2, 2, 0);
    send_pair(1, 4, 4, 0);
    send_pair(1, 15, 15, 0);
    send_pair(1, 6, 1, 0);
    finish_run(1, SC1);
    check("dut1 restart correct", 32'(correct_count[1]), 2);
    check("dut1 restart bad", 32'(bad_label[1]), 1);

    // Out-of-range label.
    do_start(2);
    send_pair(2, 12, 12, 0);
    send_pair(2, 5, 5, 0);
    finish_run(2, SC2);
    check("dut2 bad-label correct", 32'(correct_count[2]), 1);
    check("dut2 bad-label flag", 32'(bad_label[2]), 1);

    // Reset in the middle of a run.
    do_start(0);
    for (int i = 0; i < 100; i++) send_pair(0, i % 10, (i * 3) % 10, 0);
    pred_valid[0] = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("dut0 midreset ready", 32'(pred_ready[0]), 0);
    check("dut0 midreset busy", 32'(busy[0]), 0);
    check("dut0 midreset done", 32'(done[0]), 0);
    check("dut0 midreset total", 32'(total_count[0]), 0);
    check("dut0 midreset correct", 32'(correct_count[0]), 0);
    check("dut0 midreset bad", 32'(bad_label[0]), 0);
    rst_n = 1'b1;
    pred_valid[0] = 1'b1;
    repeat (3) begin
      @(posedge clk); #1;
      check("dut0 idle ready after reset", 32'(pred_ready[0]), 0);
      check("dut0 idle total after reset", 32'(total_count[0]), 0);
    end
    pred_valid[0] = 1'b0;

    // Random labels and random valid gaps.
    do_start(0);
    for (int i = 0; i < SC0; i++) begin
      if ($urandom_range(0, 9) == 0) p = int'($urandom_range(0, 15));
      else                           p = int'($urandom_range(0, 9));
      if ($urandom_range(0, 1) == 0) t = p;
      else                           t = int'($urandom_range(0, 10));
      send_pair(0, p, t, (i == SC0 - 1) ? 0 : int'($urandom_range(0, 2)));
    end
    finish_run(0, SC0);

    @(negedge clk);
    @(negedge clk);
    check("scoreboard drained", 32'(exp_q0.size() + exp_q1.size() + exp_q2.size()), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule : tb_accuracy_counter

// File: doc/accuracy_counter.md
# accuracy_counter

Sequential scoring stage directly downstream of the label finder. It takes one predicted label per inference together with the ground-truth label over a valid/ready handshake, and counts correct and total predictions over a fixed-size test run. When the run completes it holds the final scores with `done` asserted. The MLP top level reads the accuracy from those held scores.

## Interface
- `clog2_number_of_labels`, default 4: label width in bits.
- `number_of_labels`, default 10: number of valid classes; legal labels are 0 to `number_of_labels`-1.
- `sample_count`, default 750: number of samples per run; must be at least 1.
- `cnt_w`, default 16: counter width; must satisfy 2^`cnt_w` > `sample_count`.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: synchronous reset, active-low; the only reset.
- `start` in 1: begins a run; sampled in IDLE and DONE.
- `pred_valid` in 1: a predicted/true label pair is presented.
- `pred_ready` out 1: the block accepts a pair.
- `pred_label` in `clog2_number_of_labels`: label produced by the label finder.
- `true_label` in `clog2_number_of_labels`: ground-truth label.
- `busy` out 1: high in RUN.
- `done` out 1: high in DONE.
- `correct_count` out `cnt_w`: number of correct predictions so far.
- `total_count` out `cnt_w`: number of samples accepted so far.
- `bad_label` out 1: sticky flag; a label ≥ `number_of_labels` was accepted.
- `class_hits` out `number_of_labels`*`cnt_w`: per-class correct counts. The port exists only with `ACC_PER_CLASS_EN`.

## Operation
- FSM states: IDLE, RUN, DONE. Reset state is IDLE.
- IDLE:
  - `start`=1 → RUN; `correct_count`, `total_count`, `bad_label` and `class_hits` are cleared on the same edge.
- RUN:
  - `pred_ready`=1; a handshake is `pred_valid` && `pred_ready`.
  - On each handshake, `total_count` += 1.
  - `correct_count` += 1 when `pred_label` == `true_label` and both are < `number_of_labels`.
  - Either label out of range: the sample counts in total only, and `bad_label` is set.
  - When the handshake makes `total_count` equal `sample_count`, move to DONE on the same edge.
  - `start` is ignored in RUN.
- DONE:
  - `pred_ready`=0; counters hold.
  - `start`=1 → RUN, with the same clearing as from IDLE.
- Counters never exceed `sample_count`; there is no wrap.
- Comparison is purely on labels; no arithmetic beyond the +1 increments.
- `rst_n`=0 mid-run: everything returns to its reset value on that edge and the partial run is discarded.

## Timing
- Reset values: `pred_ready`=0, `busy`=0, `done`=0, `correct_count`=0, `total_count`=0, `bad_label`=0, `class_hits`=0.
- All outputs are registered or decoded from state only; there is no combinational path from any input to any output.
- `pred_ready` rises the cycle after `start` is sampled.
- Throughput is one sample per cycle; `pred_valid` may be held high continuously.
- Counters reflect a handshake one cycle after the accepting edge.
- `done` rises the cycle after the final handshake. On that same cycle the counts are final and `pred_ready` is 0.
- `start` together with `pred_valid` in DONE: the new run starts; the pair is not accepted on that edge.
- `pred_valid` while `pred_ready`=0: ignored, with no side effects.

## Configuration
- `ACC_PER_CLASS_EN` defined:
  - `number_of_labels` counters of `cnt_w` bits are built.
  - Counter k increments on a correct prediction of class k.
  - Out-of-range labels touch none of them.
  - The sum of all `class_hits` always equals `correct_count`.
- `ACC_PER_CLASS_EN` undefined: the bank and the `class_hits` port are absent; all other behaviour is identical.

## Structure
- Shared package `mlp_pkg`:
  - state enum `acc_state_t` (IDLE, RUN, DONE);
  - default constants `NUMBER_OF_LABELS`, `CLOG2_NUMBER_OF_LABELS`, `SAMPLE_COUNT`, `ACC_CNT_W`.
- One sub-module, `class_hit_bank`, holds the per-class counters.
  - Inputs: `clk`, `rst_n`, `clear`, `hit`, `hit_label`.
  - It is instantiated only under `ACC_PER_CLASS_EN`.

## Test plan
- Reset, then `start`; stream 750 pairs with `pred_label`=`true_label`=i%10. Expected: `correct_count`=750, `total_count`=750, `done`=1 one cycle after the last handshake, `bad_label`=0.
- `sample_count`=4; send pairs (3,3), (1,2), (7,7), (0,9). Expected: `correct_count`=2, `total_count`=4. With the macro, `class_hits`[3]=1 and [7]=1, all others 0.
- Send pairs (12,12) and (5,5) with `sample_count`=2. Expected: `correct_count`=1, `total_count`=2, `bad_label`=1.
- Drive `rst_n` low after 100 of 750 handshakes. Expected: all outputs zero on the next cycle, state IDLE, and `pred_ready`=0 until a new `start`.
- In DONE, hold `pred_valid`=1 for 5 cycles. Expected: counts unchanged. Then pulse `start` with `pred_valid`=1: counters clear, `pred_ready`=1 next cycle, and the first counted sample is the one accepted after that.
- Toggle `pred_valid` randomly over 750 samples. Expected: `total_count` equals the number of handshakes exactly, and no count changes while `pred_ready`=0.
